// File: rtl/alarm_controller.sv
// Alarm clock: one-second prescaler, hh:mm:ss timekeeping, alarm setpoint and an
// IDLE/ARMED/RINGING/SNOOZE controller with snooze and automatic ring timeout.
module alarm_controller #(
    parameter int TICK_DIV   = 50000000,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MAX_S = 60
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic [4:0] load_hh,
    input  logic [5:0] load_mm,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic       tick_out,
    output logic [1:0] state,
    output logic       ringing
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam int            PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [15:0]   RING_LAST   = 16'(RING_MAX_S - 1);
    localparam logic [15:0]   SNOOZE_LAST = 16'(SNOOZE_MIN * 60 - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic          load_ok;
    logic          load_time;
    logic          load_alarm;
    logic          alarm_hit;
    logic          enter_timed;
    logic [4:0]    hh_inc;
    logic [5:0]    mm_inc;
    logic [5:0]    ss_inc;
    logic [4:0]    alarm_hh;
    logic [5:0]    alarm_mm;
    logic [15:0]   tick_cnt;
    state_t        cur_state;
    state_t        nxt_state;

    assign tick       = (presc == PRESC_LAST);
    assign tick_out   = tick;
    assign load_ok    = (load_hh <= 5'd23) && (load_mm <= 6'd59);
    assign load_time  = set_time && load_ok;
    assign load_alarm = set_alarm && load_ok;
    assign state      = cur_state;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (load_time || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        ss_inc = ss + 6'd1;
        mm_inc = mm;
        hh_inc = hh;
        if (ss == 6'd59) begin
            ss_inc = 6'd0;
            mm_inc = mm + 6'd1;
            if (mm == 6'd59) begin
                mm_inc = 6'd0;
                hh_inc = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
            end
        end
    end

    // A set_time wins over a coincident tick, so only a genuine tick can hit the alarm.
    assign alarm_hit = tick && !load_time && (ss_inc == 6'd0) &&
                       (mm_inc == alarm_mm) && (hh_inc == alarm_hh);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hh <= '0;
            mm <= '0;
            ss <= '0;
        end else if (load_time) begin
            hh <= load_hh;
            mm <= load_mm;
            ss <= '0;
        end else if (tick) begin
            hh <= hh_inc;
            mm <= mm_inc;
            ss <= ss_inc;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            alarm_hh <= '0;
            alarm_mm <= '0;
        end else if (load_alarm) begin
            alarm_hh <= load_hh;
            alarm_mm <= load_mm;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
            ringing   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            ringing   <= (nxt_state == RINGING);
        end
    end

    always_comb begin
        nxt_state = cur_state;
        if (!alarm_en) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:    nxt_state = ARMED;
                ARMED:   if (alarm_hit) nxt_state = RINGING;
                RINGING: begin
                    if (stop)
                        nxt_state = ARMED;
                    else if (snooze)
                        nxt_state = SNOOZE;
                    else if (tick && tick_cnt == RING_LAST)
                        nxt_state = ARMED;
                end
                SNOOZE: begin
                    if (stop)
                        nxt_state = ARMED;
                    else if (tick && tick_cnt == SNOOZE_LAST)
                        nxt_state = RINGING;
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    // One shared counter times both the ring window and the snooze interval.
    assign enter_timed = (nxt_state != cur_state) &&
                         ((nxt_state == RINGING) || (nxt_state == SNOOZE));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (enter_timed) begin
            tick_cnt <= '0;
        end else if (tick && ((cur_state == RINGING) || (cur_state == SNOOZE))) begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Randomized scoreboard bench for alarm_controller against a seconds-of-day
// reference model, with directed wrap, alarm, snooze, load and reset scenarios.
module tb_alarm_controller;

    localparam int TICK_DIV   = 4;
    localparam int SNOOZE_MIN = 1;
    localparam int RING_MAX_S = 60;
    localparam int DAY        = 86400;

    localparam int S_IDLE   = 0;
    localparam int S_ARMED  = 1;
    localparam int S_RING   = 2;
    localparam int S_SNOOZE = 3;

    logic       clk_in    = 1'b0;
    logic       rst       = 1'b0;
    logic       set_time  = 1'b0;
    logic       set_alarm = 1'b0;
    logic [4:0] load_hh   = '0;
    logic [5:0] load_mm   = '0;
    logic       alarm_en  = 1'b0;
    logic       snooze    = 1'b0;
    logic       stop      = 1'b0;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       tick_out;
    logic [1:0] state;
    logic       ringing;

    typedef struct {
        int hh;
        int mm;
        int ss;
        int tick;
        int st;
        int ring;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int m_secs;
    int m_presc;
    int m_alarm;
    int m_state;
    int m_cnt;

    alarm_controller #(
        .TICK_DIV  (TICK_DIV),
        .SNOOZE_MIN(SNOOZE_MIN),
        .RING_MAX_S(RING_MAX_S)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .set_time (set_time),
        .set_alarm(set_alarm),
        .load_hh  (load_hh),
        .load_mm  (load_mm),
        .alarm_en (alarm_en),
        .snooze   (snooze),
        .stop     (stop),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss),
        .tick_out (tick_out),
        .state    (state),
        .ringing  (ringing)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkField(input string name, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        checkField("hh",       int'(hh),       e.hh);
        checkField("mm",       int'(mm),       e.mm);
        checkField("ss",       int'(ss),       e.ss);
        checkField("tick_out", int'(tick_out), e.tick);
        checkField("state",    int'(state),    e.st);
        checkField("ringing",  int'(ringing),  e.ring);
    endtask

    task automatic modelReset();
        m_secs  = 0;
        m_presc = 0;
        m_alarm = 0;
        m_state = S_IDLE;
        m_cnt   = 0;
    endtask

    // Whole-day behaviour: time is a seconds counter, the alarm a seconds-of-day target.
    task automatic modelStep(input bit st, input bit sa, input int lh, input int lm,
                             input bit en, input bit sn, input bit sp);
        bit tick;
        bit ok;
        bit hit;
        tick    = (m_presc == TICK_DIV - 1);
        ok      = (lh <= 23) && (lm <= 59);
        hit     = 1'b0;
        m_presc = tick ? 0 : m_presc + 1;
        if (st && ok) begin
            m_secs  = lh * 3600 + lm * 60;
            m_presc = 0;
        end else if (tick) begin
            m_secs = (m_secs + 1) % DAY;
            hit    = (m_secs == m_alarm);
        end
        if (sa && ok)
            m_alarm = lh * 3600 + lm * 60;
        if (!en) begin
            m_state = S_IDLE;
        end else begin
            case (m_state)
                S_IDLE:  m_state = S_ARMED;
                S_ARMED: if (hit) begin
                    m_state = S_RING;
                    m_cnt   = 0;
                end
                S_RING: begin
                    if (sp) begin
                        m_state = S_ARMED;
                    end else if (sn) begin
                        m_state = S_SNOOZE;
                        m_cnt   = 0;
                    end else if (tick) begin
                        m_cnt++;
                        if (m_cnt >= RING_MAX_S) m_state = S_ARMED;
                    end
                end
                S_SNOOZE: begin
                    if (sp) begin
                        m_state = S_ARMED;
                    end else if (tick) begin
                        m_cnt++;
                        if (m_cnt >= SNOOZE_MIN * 60) begin
                            m_state = S_RING;
                            m_cnt   = 0;
                        end
                    end
                end
                default: m_state = S_IDLE;
            endcase
        end
    endtask

    task automatic driveNow(input logic st, input logic sa, input logic [4:0] lh,
                            input logic [5:0] lm, input logic en, input logic sn,
                            input logic sp);
        exp_t e;
        set_time  = st;
        set_alarm = sa;
        load_hh   = lh;
        load_mm   = lm;
        alarm_en  = en;
        snooze    = sn;
        stop      = sp;
        modelStep(st, sa, int'(lh), int'(lm), en, sn, sp);
        e.hh   = m_secs / 3600;
        e.mm   = (m_secs / 60) % 60;
        e.ss   = m_secs % 60;
        e.tick = (m_presc == TICK_DIV - 1) ? 1 : 0;
        e.st   = m_state;
        e.ring = (m_state == S_RING) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic st, input logic sa, input logic [4:0] lh,
                                 input logic [5:0] lm, input logic en, input logic sn,
                                 input logic sp);
        @(negedge clk_in);
        driveNow(st, sa, lh, lm, en, sn, sp);
    endtask

    task automatic idleCycles(input int n, input logic en);
        repeat (n) applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, en, 1'b0, 1'b0);
    endtask

    task automatic runUntilState(input int target, input int budget, input logic en);
        int n;
        n = 0;
        while (m_state != target && n < budget) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, en, 1'b0, 1'b0);
            n++;
        end
        if (m_state != target) begin
            miscompares++;
            $display("[TB] FAIL wait_state: state %0d, expected %0d within %0d cycles",
                     m_state, target, budget);
        end
    endtask

    // Reset lands between clock edges, so outputs must clear with no edge in between.
    task automatic doReset();
        exp_t z;
        z = '{hh: 0, mm: 0, ss: 0, tick: 0, st: 0, ring: 0};
        @(negedge clk_in);
        set_time  = 1'b0;
        set_alarm = 1'b0;
        snooze    = 1'b0;
        stop      = 1'b0;
        rst       = 1'b1;
        #1;
        checkOutput(z);
        modelReset();
        @(negedge clk_in);
        rst = 1'b0;
        driveNow(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic randomPhase(input int n);
        for (int i = 0; i < n; i++) begin
            logic       st;
            logic       sa;
            logic       en;
            logic       sn;
            logic       sp;
            logic [4:0] lh;
            logic [5:0] lm;
            int         nm;
            en = ($urandom_range(0, 299) != 0);
            st = ($urandom_range(0, 199) == 0);
            sa = ($urandom_range(0, 99) == 0);
            sn = ($urandom_range(0, 59) == 0);
            sp = ($urandom_range(0, 149) == 0);
            lh = 5'($urandom_range(0, 25));
            lm = 6'($urandom_range(0, 63));
            if (sa && $urandom_range(0, 3) != 0) begin
                nm = (m_secs / 60 + 1) % 1440;
                lh = 5'(nm / 60);
                lm = 6'(nm % 60);
            end
            if ($urandom_range(0, 1499) == 0)
                doReset();
            else
                applyStimulus(st, sa, lh, lm, en, sn, sp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : driver
        exp_t z;
        z = '{hh: 0, mm: 0, ss: 0, tick: 0, st: 0, ring: 0};
        rst = 1'b1;
        @(negedge clk_in);
        checkOutput(z);
        modelReset();
        @(negedge clk_in);
        rst = 1'b0;
        driveNow(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] midnight rollover from 23:59");
        applyStimulus(1'b1, 1'b0, 5'd23, 6'd59, 1'b0, 1'b0, 1'b0);
        idleCycles(60 * TICK_DIV, 1'b0);

        $display("[TB] alarm at 00:01, ring then timeout");
        applyStimulus(1'b0, 1'b1, 5'd0, 6'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        runUntilState(S_RING, 70 * TICK_DIV, 1'b1);
        runUntilState(S_ARMED, 70 * TICK_DIV, 1'b1);

        $display("[TB] snooze and stop");
        applyStimulus(1'b1, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        runUntilState(S_RING, 70 * TICK_DIV, 1'b1);
        idleCycles(10, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0);
        runUntilState(S_RING, 70 * TICK_DIV, 1'b1);
        idleCycles(7, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b1);
        idleCycles(3, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b1);
        idleCycles(3, 1'b1);

        $display("[TB] invalid loads and set_time on the tick cycle");
        applyStimulus(1'b1, 1'b0, 5'd24, 6'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd12, 6'd60, 1'b1, 1'b0, 1'b0);
        idleCycles(2, 1'b1);
        for (int k = 0; k < 2 * TICK_DIV && m_presc != TICK_DIV - 1; k++)
            applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd1, 6'd2, 1'b1, 1'b0, 1'b0);
        idleCycles(3 * TICK_DIV, 1'b1);

        $display("[TB] alarm_en dropped in snooze, reset while ringing");
        applyStimulus(1'b0, 1'b1, 5'd1, 6'd3, 1'b1, 1'b0, 1'b0);
        runUntilState(S_RING, 70 * TICK_DIV, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0);
        idleCycles(20, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        idleCycles(2, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd1, 6'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd1, 6'd3, 1'b1, 1'b0, 1'b0);
        runUntilState(S_RING, 70 * TICK_DIV, 1'b1);
        idleCycles(9, 1'b1);
        doReset();

        $display("[TB] randomized traffic");
        randomPhase(4000);
        idleCycles(4, 1'b1);

        @(negedge clk_in);
        @(negedge clk_in);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk_in cycles per one-second tick (50 MHz board clock).
REQ-002 Parameter SNOOZE_MIN, default 5: snooze duration in minutes.
REQ-003 Parameter RING_MAX_S, default 60: seconds of ringing before auto-stop.
REQ-004 clk_in  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 set_time  input  1  one-cycle pulse: load time from load_hh/load_mm.
REQ-007 set_alarm  input  1  one-cycle pulse: load alarm setpoint from load_hh/load_mm.
REQ-008 load_hh  input  5  hour value, 0-23.
REQ-009 load_mm  input  6  minute value, 0-59.
REQ-010 alarm_en  input  1  level: alarm armed when 1.
REQ-011 snooze  input  1  one-cycle pulse: snooze request.
REQ-012 stop  input  1  one-cycle pulse: silence the alarm.
REQ-013 hh, mm, ss  output  5/6/6  current time, registered.
REQ-014 tick_out  output  1  one-cycle pulse per second.
REQ-015 state  output  2  FSM state: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-016 ringing  output  1  1 iff state==RINGING, registered.

Function
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick_out SHALL be 1 exactly in the cycle the count equals TICK_DIV-1.
REQ-018 On the edge where tick_out=1, ss SHALL increment; 59->0 carries to mm; mm 59->0 carries to hh; hh 23->0; 23:59:59 SHALL become 00:00:00.
REQ-019 set_time SHALL load hh/mm, clear ss and clear the prescaler on the next edge; it SHALL override a coincident tick.
REQ-020 set_alarm SHALL load the alarm hour/minute registers (reset 00:00) on the next edge; set_time and set_alarm together SHALL both load.
REQ-021 A load with load_hh>23 or load_mm>59 SHALL be ignored entirely (no register changes, prescaler not cleared).
REQ-022 Loads SHALL NOT change FSM state.
REQ-023 alarm_en=0 SHALL force IDLE on the next edge from any state, highest priority.
REQ-024 IDLE->ARMED on the edge where alarm_en=1.
REQ-025 ARMED->RINGING on a tick edge whose incremented time equals alarm hh:mm:00; hh/mm/ss and state SHALL update on the same edge.
REQ-026 A set_time landing on the alarm minute SHALL NOT trigger ringing; only tick-driven matches trigger.
REQ-027 RINGING: stop -> ARMED; else snooze -> SNOOZE; else after RING_MAX_S ticks in RINGING -> ARMED (priority stop > snooze > timeout).
REQ-028 SNOOZE: stop -> ARMED; else after SNOOZE_MIN*60 ticks -> RINGING.
REQ-029 A single internal 16-bit tick counter SHALL be cleared on entry to RINGING or SNOOZE and increment on each tick while in them.
REQ-030 snooze or stop in IDLE or ARMED SHALL be ignored.
REQ-031 Alarm match in ARMED SHALL occur once per day; re-arming after stop SHALL not re-ring in the same minute, since the match requires ss==0.

Reset
REQ-032 rst=1 SHALL asynchronously clear prescaler, time, alarm registers and tick counter, set state=IDLE, ringing=0, tick_out=0.
REQ-033 After rst deasserts, the first tick_out SHALL occur TICK_DIV cycles later; reset mid-ring SHALL return to IDLE with ringing=0 immediately.

Verification
REQ-034 Use TICK_DIV=4, SNOOZE_MIN=1, RING_MAX_S=60 for all directed scenarios.
REQ-035 set_time 23:59, run 60 ticks -> hh:mm:ss=00:00:00, tick_out period exactly 4 cycles.
REQ-036 set_alarm 00:01, alarm_en=1, set_time 00:00 -> state=ARMED; on the 60th tick edge state=RINGING, ringing=1, time=00:01:00; 60 more ticks -> ARMED, ringing=0.
REQ-037 During RINGING pulse snooze -> SNOOZE, ringing=0; after 60 ticks -> RINGING; stop -> ARMED.
REQ-038 set_time 24:00 and 12:60 -> time unchanged; set_time 01:02 in the tick_out cycle -> 01:02:00, prescaler restarts at 0.
REQ-039 alarm_en dropped in SNOOZE -> IDLE next edge; rst pulsed mid-RINGING -> all outputs 0 and state=IDLE without waiting for a clock edge.
